// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one single-port SRAM between instr and data ports
// Out-of-range accesses are granted but answered with an error instead of touching the memory.
module sram_port_arbiter #(
  parameter int unsigned MemSize    = 65536,
  parameter logic [31:0] MemStart   = 32'h0000_0000,
  parameter int          MemLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] AddrMask = ~(MemSize - 32'd1);
  localparam int          Last     = MemLatency - 1;

  logic                  last_data_q, last_data_d;
  logic [MemLatency-1:0] vld_q, src_q, err_q;
  logic                  vld_d, src_d, err_d;

  logic        instr_win, data_win, any_win, in_range;
  logic [31:0] win_addr;

  // last_data_q = 1 means the data port won the previous grant, so instruction wins a tie
  assign instr_win = instr_req_i & (~data_req_i | last_data_q);
  assign data_win  = data_req_i & ~instr_win;
  assign any_win   = instr_win | data_win;
  assign win_addr  = data_win ? data_addr_i : instr_addr_i;
  assign in_range  = (win_addr & AddrMask) == MemStart;

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  assign mem_req_o   = any_win & in_range;
  assign mem_we_o    = mem_req_o & data_win & data_we_i;
  assign mem_be_o    = !mem_req_o ? 4'h0 : (data_win ? data_be_i : 4'hF);
  assign mem_addr_o  = mem_req_o ? win_addr : 32'h0;
  assign mem_wdata_o = (mem_req_o & data_win) ? data_wdata_i : 32'h0;

  assign last_data_d = any_win ? data_win : last_data_q;
  assign vld_d       = any_win;
  assign src_d       = data_win;
  assign err_d       = any_win & ~in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_data_q <= 1'b1;
      vld_q       <= '0;
      src_q       <= '0;
      err_q       <= '0;
    end else begin
      last_data_q <= last_data_d;
      vld_q[0]    <= vld_d;
      src_q[0]    <= src_d;
      err_q[0]    <= err_d;
      for (int i = 1; i < MemLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        src_q[i] <= src_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  logic        rsp_vld, rsp_src, rsp_err;
  logic [31:0] rsp_data;

  assign rsp_vld  = vld_q[Last];
  assign rsp_src  = src_q[Last];
  assign rsp_err  = err_q[Last];
  assign rsp_data = (rsp_vld & ~rsp_err) ? mem_rdata_i : 32'h0;

  assign instr_rvalid_o = rsp_vld & ~rsp_src;
  assign instr_err_o    = rsp_vld & ~rsp_src & rsp_err;
  assign instr_rdata_o  = (rsp_vld & ~rsp_src) ? rsp_data : 32'h0;
  assign data_rvalid_o  = rsp_vld & rsp_src;
  assign data_err_o     = rsp_vld & rsp_src & rsp_err;
  assign data_rdata_o   = (rsp_vld & rsp_src) ? rsp_data : 32'h0;

  // The memory must answer exactly the in-range accesses, at exactly MemLatency
  a_mem_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i == (rsp_vld & ~rsp_err));
  a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_rvalid_o & data_rvalid_o));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
// Two instances (latency 1 and 3) share the same request stimulus, each with its own SRAM.
module tb_sram_port_arbiter;

  localparam int unsigned MEM_SIZE  = 65536;
  localparam logic [31:0] MEM_START = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;

  logic        igt [2], dgt [2], irv [2], ierr [2], drv [2], derr [2];
  logic        mreq [2], mwe [2], mrv [2];
  logic [3:0]  mbe [2];
  logic [31:0] ird [2], drd [2], maddr [2], mwd [2], mrd [2];
  logic [139:0] obs [2];

  function automatic logic [31:0] init_word(int i);
    if (i == 32) return 32'h0000_0013;
    if (i == 64) return 32'h0;
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = (k == 0) ? 1 : 3;
    logic [31:0] sram [0:16383];
    logic        rv_p [L];
    logic [31:0] rd_p [L];

    sram_port_arbiter #(.MemSize(MEM_SIZE), .MemStart(MEM_START), .MemLatency(L)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(igt[k]),
      .instr_rvalid_o(irv[k]), .instr_rdata_o(ird[k]), .instr_err_o(ierr[k]),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(dgt[k]),
      .data_rvalid_o(drv[k]), .data_rdata_o(drd[k]), .data_err_o(derr[k]),
      .mem_req_o(mreq[k]), .mem_we_o(mwe[k]), .mem_be_o(mbe[k]), .mem_addr_o(maddr[k]),
      .mem_wdata_o(mwd[k]), .mem_rvalid_i(mrv[k]), .mem_rdata_i(mrd[k])
    );

    initial for (int i = 0; i < 16384; i++) sram[i] = init_word(i);

    // Read-before-write SRAM: every access returns the word as it was before the access
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < L; i++) begin rv_p[i] <= 1'b0; rd_p[i] <= 32'h0; end
      end else begin
        for (int i = 1; i < L; i++) begin rv_p[i] <= rv_p[i-1]; rd_p[i] <= rd_p[i-1]; end
        rv_p[0] <= mreq[k];
        rd_p[0] <= mreq[k] ? sram[maddr[k][15:2]] : 32'h0;
        if (mreq[k] && mwe[k])
          for (int b = 0; b < 4; b++)
            if (mbe[k][b]) sram[maddr[k][15:2]][8*b +: 8] = mwd[k][8*b +: 8];
      end
    end

    assign mrv[k] = rv_p[L-1];
    assign mrd[k] = rd_p[L-1];
    assign obs[k] = {igt[k], dgt[k], mreq[k], mwe[k], mbe[k], maddr[k], mwd[k],
                     irv[k], ird[k], ierr[k], drv[k], drd[k], derr[k]};
  end

  typedef struct { int due; bit src; bit err; logic [31:0] data; } rsp_t;
  rsp_t         rq [2][$];
  logic [31:0]  ref_mem [0:16383];
  bit           last_data;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [139:0] exp_v [2];
  bit           m_wi, m_wd, m_inr;
  logic [31:0]  m_addr;
  int           lat [2] = '{1, 3};

  function automatic logic [31:0] rand_addr(bit allow_oor);
    if (allow_oor && $urandom_range(15) == 0) return $urandom | 32'h0001_0000;
    return 32'($urandom_range(16383)) << 2;
  endfunction

  task automatic model_reset();
    rq[0].delete();
    rq[1].delete();
    last_data = 1'b1;
  endtask

  // Expected outputs for the current cycle from the arbitration rules and pending responses
  task automatic settle();
    logic [71:0] er;
    logic [67:0] ep;
    rsp_t r;
    #1;
    m_wi   = instr_req && (!data_req || last_data);
    m_wd   = data_req && !m_wi;
    m_addr = m_wd ? data_addr : instr_addr;
    m_inr  = (m_addr & ~(MEM_SIZE - 32'd1)) == MEM_START;
    if ((m_wi || m_wd) && m_inr)
      er = {m_wi, m_wd, 1'b1, m_wd & data_we, m_wd ? data_be : 4'hF, m_addr,
            m_wd ? data_wdata : 32'h0};
    else
      er = {m_wi, m_wd, 70'h0};
    for (int k = 0; k < 2; k++) begin
      ep = '0;
      if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
        r = rq[k][0];
        if (r.src) ep = {1'b0, 32'h0, 1'b0, 1'b1, r.data, r.err};
        else       ep = {1'b1, r.data, r.err, 1'b0, 32'h0, 1'b0};
      end
      exp_v[k] = {er, ep};
    end
  endtask

  task automatic tick();
    rsp_t r;
    int idx;
    for (int k = 0; k < 2; k++)
      if (rq[k].size() > 0 && rq[k][0].due == cyc) void'(rq[k].pop_front());
    if (m_wi || m_wd) begin
      idx    = int'(m_addr[15:2]);
      r.src  = m_wd;
      r.err  = !m_inr;
      r.data = m_inr ? ref_mem[idx] : 32'h0;
      if (m_wd && data_we && m_inr)
        for (int b = 0; b < 4; b++)
          if (data_be[b]) ref_mem[idx][8*b +: 8] = data_wdata[8*b +: 8];
      last_data = m_wd;
      for (int k = 0; k < 2; k++) begin
        r.due = cyc + lat[k];
        rq[k].push_back(r);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs[k] !== '0) begin bad++; $display("FAIL reset_outputs inst=%0d got=%h exp=0", k, obs[k]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit was_i;
    instr_req = 1'b1; instr_addr = rand_addr(0);
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = rand_addr(0);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) begin instr_req = 1'b0; data_req = 1'b0; end
      settle();
      if (c < 4) begin
        total++;
        if (igt[0] !== (c % 2 == 0)) begin bad++; $display("FAIL contention_order c=%0d instr_gnt got=%b exp=%b", c, igt[0], (c % 2 == 0)); end
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL contention inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
      end
      was_i = igt[0];
      tick();
      if (c < 4) begin
        if (was_i) instr_addr = rand_addr(0);
        else       data_addr  = rand_addr(0);
      end
    end
  endtask

  task automatic test_instr_only();
    instr_req = 1'b1; instr_addr = 32'h80;
    for (int c = 0; c < 5; c++) begin
      settle();
      if (c == 0) begin
        total++;
        if (igt[0] !== 1'b1 || mreq[0] !== 1'b1) begin bad++; $display("FAIL instr_only_gnt got=%b%b exp=11", igt[0], mreq[0]); end
      end
      if (c == 1) begin
        total++;
        if (irv[0] !== 1'b1 || ird[0] !== 32'h13 || drv[0] !== 1'b0) begin bad++; $display("FAIL instr_only_rsp got=%b/%h/%b exp=1/00000013/0", irv[0], ird[0], drv[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL instr_only inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
      end
      tick();
      instr_req = 1'b0;
    end
  endtask

  task automatic test_write_read();
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011; data_addr = 32'h100; data_wdata = 32'hAABB_CCDD;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (c == 1) begin
        total++;
        if (drv[0] !== 1'b1) begin bad++; $display("FAIL write_ack got=%b exp=1", drv[0]); end
      end
      if (c == 2) begin
        total++;
        if (drv[0] !== 1'b1 || drd[0] !== 32'h0000_CCDD) begin bad++; $display("FAIL readback got=%b/%h exp=1/0000ccdd", drv[0], drd[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL write_read inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
      end
      tick();
      if (c == 0) begin data_we = 1'b0; data_be = 4'hF; data_wdata = 32'h0; end
      if (c == 1) data_req = 1'b0;
    end
  endtask

  task automatic test_out_of_range();
    int err_seen = 0;
    int instr_ok = 0;
    bit gi, gd;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0001_0000;
    instr_req = 1'b1; instr_addr = 32'h84;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (dgt[0] === 1'b1) begin
        total++;
        if (mreq[0] !== 1'b0) begin bad++; $display("FAIL oor_mem_req got=%b exp=0", mreq[0]); end
      end
      if (drv[0] === 1'b1 && derr[0] === 1'b1 && drd[0] === 32'h0) err_seen++;
      if (irv[0] === 1'b1 && ierr[0] === 1'b0 && ird[0] === init_word(33)) instr_ok++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL oor inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
      end
      gi = m_wi; gd = m_wd;
      tick();
      if (gi) instr_req = 1'b0;
      if (gd) data_req = 1'b0;
    end
    total++;
    if (err_seen != 1 || instr_ok != 1) begin bad++; $display("FAIL oor_responses err_rsp got=%0d exp=1 instr_rsp got=%0d exp=1", err_seen, instr_ok); end
  endtask

  task automatic test_random_stream(input int n);
    int grants = 0;
    int seen [2];
    bit gi = 1'b1;
    bit gd = 1'b1;
    seen[0] = 0; seen[1] = 0;
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) begin
        if (!instr_req || gi) begin instr_req = ($urandom_range(7) != 0); instr_addr = rand_addr(1); end
        if (!data_req || gd) begin
          data_req = ($urandom_range(2) == 0); data_we = 1'($urandom_range(1));
          data_be = 4'($urandom_range(15)); data_addr = rand_addr(1); data_wdata = $urandom;
        end
      end else begin
        instr_req = 1'b0; data_req = 1'b0;
      end
      settle();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL stream inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
        seen[k] += int'(irv[k]) + int'(drv[k]);
      end
      gi = m_wi; gd = m_wd;
      grants += int'(m_wi | m_wd);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (seen[k] != grants) begin bad++; $display("FAIL stream_count inst=%0d got=%0d exp=%0d", k, seen[k], grants); end
    end
  endtask

  task automatic test_reset_midflight();
    bit gi, gd;
    instr_req = 1'b1; instr_addr = rand_addr(0);
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = rand_addr(0);
    for (int c = 0; c < 2; c++) begin
      settle();
      gi = m_wi; gd = m_wd;
      tick();
      if (gi) instr_req = 1'b0;
      if (gd) data_req = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({irv[0], drv[0], irv[1], drv[1]} !== 4'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0000", {irv[0], drv[0], irv[1], drv[1]}); end
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rst_n = 1'b1;
      if (c == 7) begin instr_req = 1'b1; data_req = 1'b1; end
      settle();
      if (c == 7) begin
        total++;
        if (igt[0] !== 1'b1 || dgt[0] !== 1'b0) begin bad++; $display("FAIL reset_first_contention got=%b%b exp=10", igt[0], dgt[0]); end
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs[k] !== exp_v[k]) begin bad++; $display("FAIL reset_mid inst=%0d cyc=%0d got=%h exp=%h", k, cyc, obs[k], exp_v[k]); end
      end
      tick();
    end
    instr_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_contention();
    test_instr_only();
    test_write_read();
    test_out_of_range();
    test_random_stream(600);
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
